// File: rtl/ecc_pkg.sv
// ecc_pkg: shared SECDED helpers and the scrubber state encoding.
// Codeword layout: Hamming bits at indices 0..cw-1 (index = position-1,
// check bits at power-of-two positions), overall even parity at index cw.
package ecc_pkg;

    // Number of Hamming check bits needed to cover data_width data bits.
    function automatic int get_parity_width(input int data_width);
        int p;
        p = 1;
        while ((1 << p) < (data_width + p + 1)) begin
            p++;
        end
        return p;
    endfunction

    // Hamming codeword width without the overall parity bit.
    function automatic int get_cw_width(input int data_width);
        return data_width + get_parity_width(data_width);
    endfunction

    typedef enum logic [1:0] {
        SCRUB_IDLE  = 2'd0,
        SCRUB_READ  = 2'd1,
        SCRUB_WAIT  = 2'd2,
        SCRUB_WRITE = 2'd3
    } scrub_state_e;

endpackage

// File: rtl/ecc_decode.sv
// ecc_decode: SECDED decoder, purely combinational.
// single_error_o: one Hamming bit flipped (corrected in data_o).
// parity_error_o: only the overall parity bit flipped (data intact).
// double_error_o: two bits flipped, or a syndrome pointing outside the word.
module ecc_decode
    import ecc_pkg::*;
#(
    parameter int DataWidth  = 32,
    localparam int CwWidth   = get_cw_width(DataWidth),
    localparam int ParWidth  = get_parity_width(DataWidth)
) (
    input  logic [CwWidth:0]     data_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 single_error_o,
    output logic                 parity_error_o,
    output logic                 double_error_o
);

    // Syndrome, overall parity check, single-bit correction and data gather.
    always_comb begin : decode_comb
        logic [ParWidth-1:0] syn;
        logic [CwWidth-1:0]  cw;
        logic                par_bad;
        int                  di;
        syn = '0;
        for (int pos = 1; pos <= CwWidth; pos++) begin
            if (data_i[pos-1]) begin
                syn = syn ^ ParWidth'(pos);
            end
        end
        par_bad        = ^data_i;
        single_error_o = par_bad && (syn != '0) && (int'(syn) <= CwWidth);
        parity_error_o = par_bad && (syn == '0);
        double_error_o = (!par_bad && (syn != '0)) || (par_bad && (int'(syn) > CwWidth));
        cw = data_i[CwWidth-1:0];
        if (single_error_o) begin
            cw[int'(syn) - 1] = ~cw[int'(syn) - 1];
        end
        data_o = '0;
        di = 0;
        for (int pos = 1; pos <= CwWidth; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                data_o[di] = cw[pos-1];
                di++;
            end
        end
    end

endmodule

// File: rtl/ecc_encode.sv
// ecc_encode: SECDED encoder (Hamming + overall parity), purely combinational.
module ecc_encode
    import ecc_pkg::*;
#(
    parameter int DataWidth  = 32,
    localparam int CwWidth   = get_cw_width(DataWidth),
    localparam int ParWidth  = get_parity_width(DataWidth)
) (
    input  logic [DataWidth-1:0] data_i,
    output logic [CwWidth:0]     code_o
);

    logic [CwWidth-1:0] cw;

    // Scatter data into non-power-of-two positions, then fill each check bit.
    always_comb begin : encode_comb
        int di;
        cw = '0;
        di = 0;
        for (int pos = 1; pos <= CwWidth; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos-1] = data_i[di];
                di++;
            end
        end
        for (int p = 0; p < ParWidth; p++) begin
            for (int pos = 1; pos <= CwWidth; pos++) begin
                if ((((pos >> p) & 1) != 0) && (pos != (1 << p))) begin
                    cw[(1 << p) - 1] = cw[(1 << p) - 1] ^ cw[pos-1];
                end
            end
        end
    end

    assign code_o = {^cw, cw};

endmodule

// File: rtl/ecc_scrubber.sv
// ecc_scrubber: background SECDED scrubber for one SRAM bank.
// Walks the bank one word per ScrubInterval idle cycles, writes back
// correctable words re-encoded, and flags uncorrectable ones.
// Build option ECC_SCRUBBER_STATS_EN adds the saturating corrected /
// uncorrectable counters and the last-error address register; without it
// those outputs are tied to 0.
// Handshake: scrub_req_o is held with stable we/addr/wdata until the cycle in
// which scrub_gnt_i is high; that cycle completes the transfer, and read data
// arrives on scrub_rdata_i in the next cycle. A request is never withdrawn.
module ecc_scrubber
    import ecc_pkg::*;
#(
    parameter int BankSize      = 256,
    parameter int DataWidth     = 32,
    parameter int ScrubInterval = 64,
    localparam int AddrWidth    = $clog2(BankSize),
    localparam int EncWidth     = get_cw_width(DataWidth) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    output logic                 scrub_req_o,
    input  logic                 scrub_gnt_i,
    output logic                 scrub_we_o,
    output logic [AddrWidth-1:0] scrub_addr_o,
    output logic [EncWidth-1:0]  scrub_wdata_o,
    input  logic [EncWidth-1:0]  scrub_rdata_i,
    output logic                 lock_o,
    output logic                 pass_done_o,
    output logic                 uncorrectable_o,
    output logic [AddrWidth-1:0] err_addr_o,
    output logic [31:0]          nb_corrected_o,
    output logic [31:0]          nb_uncorrectable_o
);

    localparam int CntWidth = (ScrubInterval > 1) ? $clog2(ScrubInterval) : 1;
    localparam logic [CntWidth-1:0]  CntReload = CntWidth'(ScrubInterval - 1);
    localparam logic [AddrWidth-1:0] AddrLast  = AddrWidth'(BankSize - 1);

    scrub_state_e         state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [EncWidth-1:0]  wdata_q, wdata_d;

    logic [DataWidth-1:0] dec_data;
    logic                 dec_single;
    logic                 dec_parity;
    logic                 dec_double;
    logic [EncWidth-1:0]  enc_word;
    logic                 correctable;
    logic                 advance;

    ecc_decode #(.DataWidth(DataWidth)) u_decode (
        .data_i         (scrub_rdata_i),
        .data_o         (dec_data),
        .single_error_o (dec_single),
        .parity_error_o (dec_parity),
        .double_error_o (dec_double)
    );

    ecc_encode #(.DataWidth(DataWidth)) u_encode (
        .data_i (dec_data),
        .code_o (enc_word)
    );

    // A word is done in WAIT when no writeback is needed, or on the write grant.
    assign correctable = (state_q == SCRUB_WAIT) && (dec_single || dec_parity);
    assign advance     = ((state_q == SCRUB_WAIT) && !(dec_single || dec_parity))
                       || ((state_q == SCRUB_WRITE) && scrub_gnt_i);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SCRUB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; enable_i is only consulted in IDLE so a word always completes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SCRUB_IDLE: begin
                if (enable_i && (cnt_q == '0)) state_d = SCRUB_READ;
            end
            SCRUB_READ: begin
                if (scrub_gnt_i) state_d = SCRUB_WAIT;
            end
            SCRUB_WAIT: begin
                state_d = correctable ? SCRUB_WRITE : SCRUB_IDLE;
            end
            SCRUB_WRITE: begin
                if (scrub_gnt_i) state_d = SCRUB_IDLE;
            end
            default: state_d = SCRUB_IDLE;
        endcase
    end

    // Outputs decoded from the current state (plus same-cycle status pulses).
    always_comb begin
        scrub_req_o     = (state_q == SCRUB_READ) || (state_q == SCRUB_WRITE);
        scrub_we_o      = (state_q == SCRUB_WRITE);
        scrub_addr_o    = scrub_req_o ? addr_q : '0;
        lock_o          = (state_q != SCRUB_IDLE);
        pass_done_o     = advance && (addr_q == AddrLast);
        uncorrectable_o = (state_q == SCRUB_WAIT) && dec_double;
    end

    // Interval counter, address walk and writeback word next values.
    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = '0;
        if ((state_q == SCRUB_IDLE) && enable_i) begin
            cnt_d = (cnt_q == '0) ? CntReload : cnt_q - CntWidth'(1);
        end
        if (advance) begin
            addr_d = (addr_q == AddrLast) ? '0 : addr_q + AddrWidth'(1);
        end
        if (correctable) begin
            wdata_d = enc_word;
        end else if ((state_q == SCRUB_WRITE) && !scrub_gnt_i) begin
            wdata_d = wdata_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= CntReload;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign scrub_wdata_o = wdata_q;

`ifdef ECC_SCRUBBER_STATS_EN
    logic [31:0]          nb_corr_q, nb_corr_d;
    logic [31:0]          nb_unc_q, nb_unc_d;
    logic [AddrWidth-1:0] err_addr_q, err_addr_d;

    // Saturating event counters and last uncorrectable address.
    always_comb begin
        nb_corr_d  = nb_corr_q;
        nb_unc_d   = nb_unc_q;
        err_addr_d = err_addr_q;
        if (correctable && (nb_corr_q != '1)) begin
            nb_corr_d = nb_corr_q + 32'd1;
        end
        if (uncorrectable_o) begin
            err_addr_d = addr_q;
            if (nb_unc_q != '1) nb_unc_d = nb_unc_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            nb_corr_q  <= '0;
            nb_unc_q   <= '0;
            err_addr_q <= '0;
        end else begin
            nb_corr_q  <= nb_corr_d;
            nb_unc_q   <= nb_unc_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign nb_corrected_o     = nb_corr_q;
    assign nb_uncorrectable_o = nb_unc_q;
    assign err_addr_o         = err_addr_q;
`else
    assign nb_corrected_o     = '0;
    assign nb_uncorrectable_o = '0;
    assign err_addr_o         = '0;
`endif

endmodule
